dmem_arbiter: RTL and testbench
===============================

Name: dmem_arbiter

Overview:
- Two-port arbiter and sequencer in front of the data memory (`data_mem`).
- Port 0 is the CPU load/store path; port 1 is the debug/DMA loader.
- Round-robin arbitration grants one requester at a time.
- Drives the memory's single-cycle read/write strobes, captures read data, and returns a one-cycle acknowledge to the winner.

Parameters:
- ADDR_W, 32, requester and memory address width
- DATA_W, 32, data width

Ports:
- clk  input  1  system clock, all logic on posedge
- rst_n  input  1  asynchronous active-low reset
- p0_req  input  1  port 0 request, held high until p0_ack
- p0_we  input  1  port 0: 1 = write, 0 = read
- p0_addr  input  ADDR_W  port 0 byte address
- p0_wdata  input  DATA_W  port 0 write data
- p0_sign_mask  input  4  port 0 size/sign code, passed to memory unchanged
- p0_ack  output  1  port 0 one-cycle completion pulse
- p0_rdata  output  DATA_W  port 0 read data, valid while p0_ack=1
- p1_req, p1_we, p1_addr, p1_wdata, p1_sign_mask, p1_ack, p1_rdata: same as port 0, for port 1
- mem_addr  output  ADDR_W  to memory addr
- mem_wdata  output  DATA_W  to memory write_data
- mem_sign_mask  output  4  to memory sign_mask
- mem_read  output  1  to memory memread
- mem_write  output  1  to memory memwrite
- mem_rdata  input  DATA_W  from memory read_data, valid the cycle after the edge that sampled mem_read=1
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset is asynchronous and active-low; it is the only reset.
- While rst_n=0:
  - state=IDLE.
  - All outputs are 0, including both rdata buses.
  - The round-robin pointer last_grant=1, so port 0 wins the first contention.
- Reset mid-transaction drops the operation: no ack is issued, and the strobes deassert immediately.
- All outputs are registered; no combinational path from any input to any output.
- FSM states are IDLE, ISSUE, WAIT, RESP.
- IDLE:
  - If no request is pending, stay in IDLE.
  - If exactly one req is high, grant it.
  - If both are high, grant the port not equal to last_grant.
  - On grant: latch we/addr/wdata/sign_mask into mem_* registers, set last_grant, go to ISSUE, assert mem_read=!we or mem_write=we.
- ISSUE: the strobe is high for exactly this cycle.
  - Read: next state WAIT.
  - Write: next state RESP, with ack for the winner set at this edge.
  - Strobes clear at this edge.
- WAIT (read only): capture mem_rdata into the winner's rdata register, set the winner's ack, go to RESP.
- RESP: ack is high for exactly this cycle; next state IDLE, ack clears.
- Requester rules:
  - Keep req high and command stable until the edge that sees ack=1.
  - Drop req, or present a new command, at that edge.
  - The arbiter never samples req in RESP, so a held req is not double-granted.
- Latency, counted from the IDLE grant edge E0:
  - Read: mem_read high E0–E1; rdata captured at E2; ack high E2–E3; IDLE from E3; next sample at E4. Four cycles per read.
  - Write: mem_write high E0–E1; ack high E1–E2; IDLE from E2. Three cycles per write.
- The non-winning req waiting during a transaction is not lost. It is granted at the next IDLE edge, ahead of a re-requesting winner.
- pN_rdata holds its last captured value after ack; it is updated only on a read ack to that port.
- mem_addr, mem_wdata and mem_sign_mask hold their latched values until the next grant.
- Writes to the LED address (0x2000) are passed through like any other write; there is no decoding here.
- A single grant is never preempted. At most one of mem_read/mem_write is ever high, and at most one ack is ever high.

Test Plan:
- Reset: assert rst_n=0 mid-read (in WAIT) -> next cycle all outputs 0, state IDLE, no ack; after release p0 and p1 request together -> p0 granted first.
- Port 0 read: p0_req=1, p0_we=0, addr=0x1004, sign_mask=4'b0111; memory model returns 0xDEADBEEF -> mem_read pulses one cycle with mem_addr=0x1004; p0_ack=1, p0_rdata=0xDEADBEEF two cycles after grant; p1_ack stays 0.
- Port 1 write: p1_req=1, p1_we=1, addr=0x2000, wdata=0x000000A5 -> mem_write one cycle with mem_wdata=0xA5; p1_ack one cycle later; memory LED output = 0xA5.
- Contention: both ports hold req continuously for 6 transactions -> grants alternate 0,1,0,1,0,1; each ack is exactly one cycle; no strobe overlap.
- Back-to-back: p0 issues read, drops req at ack, and presents a write at the same edge -> write is granted at the IDLE edge following RESP; mem_read and mem_write are never high together.
- Hold/stability: after port 0's read ack, port 1 reads while p0_req=0 -> p0_rdata keeps its earlier value; p1_rdata updates only at p1_ack.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: two-port round-robin arbiter and sequencer in front of data_mem.
// Port 0 is the CPU load/store path, port 1 the debug/DMA loader. One grant at a
// time, never preempted; every output comes straight from a flop.
//
// Handshake: a requester raises pN_req with a stable command (we/addr/wdata/
// sign_mask) and holds both until the edge that samples pN_ack=1; pN_ack is a
// single-cycle pulse, and pN_rdata is valid while it is high on a read. The
// arbiter only samples requests in IDLE, so a req still high during the ack
// cycle is not granted twice.
module dmem_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              p0_req,
  input  logic              p0_we,
  input  logic [ADDR_W-1:0] p0_addr,
  input  logic [DATA_W-1:0] p0_wdata,
  input  logic [3:0]        p0_sign_mask,
  output logic              p0_ack,
  output logic [DATA_W-1:0] p0_rdata,
  input  logic              p1_req,
  input  logic              p1_we,
  input  logic [ADDR_W-1:0] p1_addr,
  input  logic [DATA_W-1:0] p1_wdata,
  input  logic [3:0]        p1_sign_mask,
  output logic              p1_ack,
  output logic [DATA_W-1:0] p1_rdata,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic [3:0]        mem_sign_mask,
  output logic              mem_read,
  output logic              mem_write,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  state_t state;
  state_t state_d;

  logic last_grant;   // port granted most recently; the other port wins a tie
  logic winner;       // port owning the transaction in flight
  logic cur_we;       // direction of the transaction in flight
  logic grant;        // a grant happens at this edge
  logic grant_port;   // which port receives it
  logic ack_set;      // raise the winner's ack at this edge
  logic capture;      // load mem_rdata into the winner's rdata at this edge

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next state, arbitration decision and per-edge control strobes
  always_comb begin
    state_d    = state;
    grant      = 1'b0;
    grant_port = 1'b0;
    ack_set    = 1'b0;
    capture    = 1'b0;
    unique case (state)
      IDLE: begin
        if (p0_req || p1_req) begin
          grant      = 1'b1;
          grant_port = (p0_req && p1_req) ? ~last_grant : p1_req;
          state_d    = ISSUE;
        end
      end
      ISSUE: begin
        if (cur_we) begin
          ack_set = 1'b1;
          state_d = RESP;
        end else begin
          state_d = WAIT;
        end
      end
      WAIT: begin
        capture = 1'b1;
        ack_set = 1'b1;
        state_d = RESP;
      end
      RESP: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  // Datapath: command latch, one-cycle strobes, acks and read-data capture
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      last_grant    <= 1'b1;
      winner        <= 1'b0;
      cur_we        <= 1'b0;
      mem_addr      <= '0;
      mem_wdata     <= '0;
      mem_sign_mask <= '0;
      mem_read      <= 1'b0;
      mem_write     <= 1'b0;
      p0_ack        <= 1'b0;
      p1_ack        <= 1'b0;
      p0_rdata      <= '0;
      p1_rdata      <= '0;
      busy          <= 1'b0;
    end else begin
      mem_read  <= 1'b0;
      mem_write <= 1'b0;
      p0_ack    <= 1'b0;
      p1_ack    <= 1'b0;
      busy      <= (state_d != IDLE);
      if (grant) begin
        winner     <= grant_port;
        last_grant <= grant_port;
        if (grant_port) begin
          cur_we        <= p1_we;
          mem_addr      <= p1_addr;
          mem_wdata     <= p1_wdata;
          mem_sign_mask <= p1_sign_mask;
          mem_read      <= ~p1_we;
          mem_write     <= p1_we;
        end else begin
          cur_we        <= p0_we;
          mem_addr      <= p0_addr;
          mem_wdata     <= p0_wdata;
          mem_sign_mask <= p0_sign_mask;
          mem_read      <= ~p0_we;
          mem_write     <= p0_we;
        end
      end
      if (ack_set) begin
        if (winner) begin
          p1_ack <= 1'b1;
        end else begin
          p0_ack <= 1'b1;
        end
      end
      if (capture) begin
        if (winner) begin
          p1_rdata <= mem_rdata;
        end else begin
          p0_rdata <= mem_rdata;
        end
      end
    end
  end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed vector table, hand-written corner sequences and
// randomized traffic for dmem_arbiter, checked cycle by cycle against a
// transaction-timing reference model plus an ack scoreboard.
module tb_dmem_arbiter;

  // ---------------- clock / reset / DUT ----------------
  logic        clk = 1'b0;
  logic        rst_n;
  logic        p0_req, p0_we, p1_req, p1_we;
  logic [31:0] p0_addr, p0_wdata, p1_addr, p1_wdata;
  logic [3:0]  p0_sign_mask, p1_sign_mask;
  logic        p0_ack, p1_ack;
  logic [31:0] p0_rdata, p1_rdata;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [3:0]  mem_sign_mask;
  logic        mem_read, mem_write, busy;

  always #5 clk = ~clk;

  dmem_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk(clk), .rst_n(rst_n),
    .p0_req(p0_req), .p0_we(p0_we), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_sign_mask(p0_sign_mask), .p0_ack(p0_ack), .p0_rdata(p0_rdata),
    .p1_req(p1_req), .p1_we(p1_we), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_sign_mask(p1_sign_mask), .p1_ack(p1_ack), .p1_rdata(p1_rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_sign_mask(mem_sign_mask),
    .mem_read(mem_read), .mem_write(mem_write), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  initial begin
    #1ms;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  // ---------------- memory environment ----------------
  function automatic logic [31:0] init_val(input logic [31:0] a);
    if (a == 32'h0000_1004) return 32'hDEAD_BEEF;
    return a ^ 32'h5A5A_0000;
  endfunction

  logic [31:0] env_mem [logic [31:0]];
  logic [31:0] led = '0;
  logic [31:0] ref_mem [logic [31:0]];

  initial mem_rdata = '0;

  // Synchronous memory: read data valid the cycle after the sampling edge
  always @(posedge clk) begin
    if (mem_read) mem_rdata <= env_mem.exists(mem_addr) ? env_mem[mem_addr] : init_val(mem_addr);
    if (mem_write) begin
      env_mem[mem_addr] = mem_wdata;
      if (mem_addr == 32'h0000_2000) led <= mem_wdata;
    end
  end

  // ---------------- bookkeeping ----------------
  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // ---------------- requester queues / driver ----------------
  typedef struct {
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
  } cmd_t;

  cmd_t q0[$];
  cmd_t q1[$];

  task automatic drive_ports();
    if (q0.size() > 0) begin
      p0_req = 1'b1; p0_we = q0[0].we; p0_addr = q0[0].addr;
      p0_wdata = q0[0].wdata; p0_sign_mask = q0[0].mask;
    end else begin
      p0_req = 1'b0; p0_we = 1'($urandom); p0_addr = $urandom;
      p0_wdata = $urandom; p0_sign_mask = 4'($urandom);
    end
    if (q1.size() > 0) begin
      p1_req = 1'b1; p1_we = q1[0].we; p1_addr = q1[0].addr;
      p1_wdata = q1[0].wdata; p1_sign_mask = q1[0].mask;
    end else begin
      p1_req = 1'b0; p1_we = 1'($urandom); p1_addr = $urandom;
      p1_wdata = $urandom; p1_sign_mask = 4'($urandom);
    end
  endtask

  function automatic cmd_t mk(input logic we, input logic [31:0] a,
                              input logic [31:0] d, input logic [3:0] m);
    cmd_t c;
    c.we = we; c.addr = a; c.wdata = d; c.mask = m;
    return c;
  endfunction

  function automatic cmd_t rand_cmd();
    logic [31:0] a;
    a = ($urandom_range(9) == 0) ? 32'h0000_2000 : 32'h0000_1000 + 32'(4 * $urandom_range(7));
    return mk(1'($urandom_range(1)), a, $urandom, 4'($urandom_range(15)));
  endfunction

  // ---------------- reference model ----------------
  // Transaction-level timing: a grant at edge S occupies the arbiter until
  // edge S+4 (read) or S+3 (write); the strobe is seen after edge S, the ack
  // after edge S+2 (read) or S+1 (write).
  int          t, m_start, m_free;
  logic        m_valid, m_we, m_port, m_last;
  logic [31:0] m_rval;
  logic [31:0] e_addr, e_wdata, e_rdata0, e_rdata1;
  logic [3:0]  e_mask;
  logic        e_read, e_write, e_ack0, e_ack1, e_busy;
  logic [33:0] exp_q[$];   // {we, port, data} per granted transaction

  task automatic model_reset();
    t = 0; m_start = 0; m_free = 0;
    m_valid = 0; m_we = 0; m_port = 0; m_last = 1'b1; m_rval = '0;
    e_addr = '0; e_wdata = '0; e_rdata0 = '0; e_rdata1 = '0; e_mask = '0;
    e_read = 0; e_write = 0; e_ack0 = 0; e_ack1 = 0; e_busy = 0;
    exp_q.delete();
  endtask

  task automatic model_edge();
    logic ack_hit;
    t++;
    if ((!m_valid || t >= m_free) && (p0_req || p1_req)) begin
      if (p0_req && p1_req) m_port = ~m_last;
      else                  m_port = p1_req;
      m_last  = m_port;
      m_valid = 1'b1;
      m_start = t;
      m_we    = m_port ? p1_we : p0_we;
      e_addr  = m_port ? p1_addr : p0_addr;
      e_wdata = m_port ? p1_wdata : p0_wdata;
      e_mask  = m_port ? p1_sign_mask : p0_sign_mask;
      m_free  = t + (m_we ? 3 : 4);
      if (m_we) begin
        ref_mem[e_addr] = e_wdata;
        exp_q.push_back({1'b1, m_port, e_wdata});
      end else begin
        m_rval = ref_mem.exists(e_addr) ? ref_mem[e_addr] : init_val(e_addr);
        exp_q.push_back({1'b0, m_port, m_rval});
      end
    end
    e_read  = m_valid && (t == m_start) && !m_we;
    e_write = m_valid && (t == m_start) && m_we;
    ack_hit = m_valid && (t == m_start + (m_we ? 1 : 2));
    e_ack0  = ack_hit && !m_port;
    e_ack1  = ack_hit && m_port;
    if (ack_hit && !m_we) begin
      if (m_port) e_rdata1 = m_rval;
      else        e_rdata0 = m_rval;
    end
    e_busy = m_valid && (t < m_free - 1);
  endtask

  // ---------------- observation logs + scoreboard ----------------
  int          strobe_t_q[$];
  logic        strobe_we_q[$];
  int          ack_t_q[$];
  logic        ack_port_q[$];
  logic [31:0] ack_data_q[$];
  logic [31:0] s_addr, s_wdata;
  logic [3:0]  s_mask;

  task automatic clear_logs();
    strobe_t_q.delete(); strobe_we_q.delete();
    ack_t_q.delete(); ack_port_q.delete(); ack_data_q.delete();
  endtask

  task automatic observe();
    logic [33:0] e;
    logic [31:0] d;
    if (mem_read || mem_write) begin
      strobe_t_q.push_back(t); strobe_we_q.push_back(mem_write);
      s_addr = mem_addr; s_wdata = mem_wdata; s_mask = mem_sign_mask;
    end
    if (p0_ack || p1_ack) begin
      d = p1_ack ? p1_rdata : p0_rdata;
      ack_t_q.push_back(t); ack_port_q.push_back(p1_ack); ack_data_q.push_back(d);
      n_tests++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL sb_unexpected_ack: got ack on port %0d, expected no ack", p1_ack);
      end else begin
        e = exp_q.pop_front();
        check("sb_port", 32'(p1_ack), 32'(e[32]));
        if (!e[33]) check("sb_rdata", d, e[31:0]);
      end
    end
  endtask

  task automatic compare_outputs();
    check("p0_ack", 32'(p0_ack), 32'(e_ack0));
    check("p1_ack", 32'(p1_ack), 32'(e_ack1));
    check("p0_rdata", p0_rdata, e_rdata0);
    check("p1_rdata", p1_rdata, e_rdata1);
    check("mem_read", 32'(mem_read), 32'(e_read));
    check("mem_write", 32'(mem_write), 32'(e_write));
    check("mem_addr", mem_addr, e_addr);
    check("mem_wdata", mem_wdata, e_wdata);
    check("mem_sign_mask", 32'(mem_sign_mask), 32'(e_mask));
    check("busy", 32'(busy), 32'(e_busy));
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_p0_ack"}, 32'(p0_ack), 0);
    check({tag, "_p1_ack"}, 32'(p1_ack), 0);
    check({tag, "_p0_rdata"}, p0_rdata, 0);
    check({tag, "_p1_rdata"}, p1_rdata, 0);
    check({tag, "_mem_addr"}, mem_addr, 0);
    check({tag, "_mem_wdata"}, mem_wdata, 0);
    check({tag, "_mem_mask"}, 32'(mem_sign_mask), 0);
    check({tag, "_mem_read"}, 32'(mem_read), 0);
    check({tag, "_mem_write"}, 32'(mem_write), 0);
    check({tag, "_busy"}, 32'(busy), 0);
  endtask

  // One clock: model advances at the edge, DUT is sampled at the negedge,
  // requesters retire on the modelled ack and present their next command.
  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    compare_outputs();
    observe();
    if (e_ack0 && q0.size() > 0) q0.delete(0);
    if (e_ack1 && q1.size() > 0) q1.delete(0);
    drive_ports();
  endtask

  task automatic drain(input string tag, input int bound);
    int n;
    n = 0;
    while ((q0.size() > 0 || q1.size() > 0 || e_busy) && n < bound) begin
      step();
      n++;
    end
    n_tests++;
    if (n >= bound) begin
      n_fail++;
      $display("FAIL %s_timeout: got %0d cycles without completion, expected under %0d", tag, n, bound);
    end
    step();
    step();
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic        port;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  mask;
    logic [31:0] exp_rdata;
    int          exp_lat;    // edges from strobe to ack
  } vec_t;

  vec_t vecs[6];
  int   exp_order[6];

  initial begin
    vecs[0] = '{1'b0, 1'b0, 32'h0000_1004, 32'h0000_0000, 4'b0111, 32'hDEAD_BEEF, 2};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_2000, 32'h0000_00A5, 4'b1111, 32'h0000_0000, 1};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_1008, 32'h0000_0000, 4'b0010, 32'h5A5A_1008, 2};
    vecs[3] = '{1'b0, 1'b1, 32'h0000_1008, 32'h1234_5678, 4'b0011, 32'h0000_0000, 1};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_1008, 32'h0000_0000, 4'b0111, 32'h1234_5678, 2};
    vecs[5] = '{1'b1, 1'b0, 32'h0000_2000, 32'h0000_0000, 4'b1111, 32'h0000_00A5, 2};
    exp_order = '{0, 1, 0, 1, 0, 1};

    // ---- reset ----
    rst_n = 1'b0;
    q0.delete(); q1.delete();
    drive_ports();
    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;

    // ---- table: single transactions with explicit expectations ----
    for (int i = 0; i < 6; i++) begin
      clear_logs();
      if (vecs[i].port) q1.push_back(mk(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask));
      else              q0.push_back(mk(vecs[i].we, vecs[i].addr, vecs[i].wdata, vecs[i].mask));
      drive_ports();
      drain("vec", 30);
      check("vec_ack_count", ack_port_q.size(), 1);
      check("vec_strobe_count", strobe_t_q.size(), 1);
      if (ack_port_q.size() == 1 && strobe_t_q.size() == 1) begin
        check("vec_port", 32'(ack_port_q[0]), 32'(vecs[i].port));
        check("vec_latency", ack_t_q[0] - strobe_t_q[0], vecs[i].exp_lat);
        check("vec_strobe_we", 32'(strobe_we_q[0]), 32'(vecs[i].we));
        check("vec_addr", s_addr, vecs[i].addr);
        check("vec_wdata", s_wdata, vecs[i].wdata);
        check("vec_mask", 32'(s_mask), 32'(vecs[i].mask));
        if (!vecs[i].we) check("vec_rdata", ack_data_q[0], vecs[i].exp_rdata);
      end
    end
    check("led_value", led, 32'h0000_00A5);
    check("hold_p0_rdata", p0_rdata, 32'h1234_5678);
    check("hold_p1_rdata", p1_rdata, 32'h0000_00A5);

    // ---- back-to-back: read then write from port 0 ----
    clear_logs();
    q0.push_back(mk(1'b0, 32'h0000_1010, 32'h0, 4'b0111));
    q0.push_back(mk(1'b1, 32'h0000_1010, 32'hCAFE_F00D, 4'b0111));
    q0.push_back(mk(1'b0, 32'h0000_1010, 32'h0, 4'b0111));
    drive_ports();
    drain("b2b", 40);
    check("b2b_strobes", strobe_t_q.size(), 3);
    if (strobe_t_q.size() == 3) begin
      check("b2b_gap", strobe_t_q[1] - strobe_t_q[0], 4);
      check("b2b_second_is_write", 32'(strobe_we_q[1]), 1);
    end
    if (ack_data_q.size() == 3) check("b2b_readback", ack_data_q[2], 32'hCAFE_F00D);

    // ---- reset in the middle of a read (WAIT) ----
    clear_logs();
    q0.push_back(mk(1'b0, 32'h0000_1014, 32'h0, 4'b0111));
    drive_ports();
    for (int n = 0; n < 10 && !e_read; n++) step();
    step();
    rst_n = 1'b0;
    #1;
    check_all_zero("midreset");
    q0.delete(); q1.delete();
    drive_ports();
    @(posedge clk);
    @(negedge clk);
    check_all_zero("midreset_hold");
    rst_n = 1'b1;
    model_reset();

    // ---- contention right after reset: p0 first, then strict alternation ----
    clear_logs();
    for (int k = 0; k < 3; k++) begin
      q0.push_back(mk(1'(k & 1), 32'h0000_1000 + 32'(4 * k), 32'h1111_0000 + 32'(k), 4'b0111));
      q1.push_back(mk(1'(~k & 1), 32'h0000_1010 + 32'(4 * k), 32'h2222_0000 + 32'(k), 4'b1111));
    end
    drive_ports();
    drain("contend", 80);
    check("contend_count", ack_port_q.size(), 6);
    for (int k = 0; k < 6 && k < ack_port_q.size(); k++)
      check("contend_order", 32'(ack_port_q[k]), exp_order[k]);

    // ---- randomized traffic against the model ----
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(3) == 0 && q0.size() < 3) q0.push_back(rand_cmd());
      if ($urandom_range(3) == 0 && q1.size() < 3) q1.push_back(rand_cmd());
      drive_ports();
      step();
    end
    drain("random", 60);
    check("sb_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
